// File: rtl/progmem_sequencer.sv
// -----------------------------------------------------------------------------
// progmem_sequencer
//
// Purpose:
//   Single owner of the program memory ports. In LOAD mode it accepts an
//   instruction stream on a valid/ready handshake and writes it to sequential
//   addresses starting at 0. In RUN mode it holds the program counter and
//   fetches one instruction per cycle into the instruction register (ir).
//   RUN mode supports decoder stall, jump (with a one-bubble flush) and
//   stopping on a halt opcode.
//
// Optional feature:
//   Defining PROGMEM_SEQ_CHECKSUM_EN adds output load_sum, the modulo-2^INS_W
//   sum of all words accepted in the current/last LOAD.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start_load, run     command pulses (start_load wins when both are set)
//   ld_valid/ld_data/ld_last/ld_ready   load stream handshake
//   stall, jump, jump_addr               fetch control from the decode stage
//   pm_load/pm_load_addr/pm_load_ins     program memory write port
//   pm_en/pm_addr/pm_ins                 program memory read port
//   ir, ir_pc, ir_valid, pc              fetch results
//   state                                0=IDLE 1=LOAD 2=RUN 3=HALTED
//   load_done, load_count, load_ovf      load status
//   load_sum                             load checksum (optional)
// -----------------------------------------------------------------------------
module progmem_sequencer #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned INS_W   = 12,
   parameter logic [3:0]  HALT_OP = 4'hF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_load,
   input  logic              run,
   input  logic              ld_valid,
   input  logic [INS_W-1:0]  ld_data,
   input  logic              ld_last,
   output logic              ld_ready,
   input  logic              stall,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_addr,
   output logic              pm_load,
   output logic [ADDR_W-1:0] pm_load_addr,
   output logic [INS_W-1:0]  pm_load_ins,
   output logic              pm_en,
   output logic [ADDR_W-1:0] pm_addr,
   input  logic [INS_W-1:0]  pm_ins,
   output logic [INS_W-1:0]  ir,
   output logic [ADDR_W-1:0] ir_pc,
   output logic              ir_valid,
   output logic [ADDR_W-1:0] pc,
   output logic [1:0]        state,
   output logic              load_done,
   output logic [ADDR_W:0]   load_count,
   output logic              load_ovf
`ifdef PROGMEM_SEQ_CHECKSUM_EN
   ,
   output logic [INS_W-1:0]  load_sum
`endif
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_RUN    = 2'd2,
      S_HALTED = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [INS_W-1:0]    ir_q, ir_d;
   logic [ADDR_W-1:0]   ir_pc_q, ir_pc_d;
   logic                ir_valid_q, ir_valid_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]     load_count_q, load_count_d;
   logic                load_done_q, load_done_d;
   logic                load_ovf_q, load_ovf_d;
`ifdef PROGMEM_SEQ_CHECKSUM_EN
   logic [INS_W-1:0]    sum_q, sum_d;
`endif

   logic                fetch_is_halt;
   logic                load_accept;

   assign fetch_is_halt = (pm_ins[INS_W-1 -: 4] == HALT_OP);

   // Write side is blocked while rst is high so a reset landing mid-LOAD
   // never modifies memory contents.
   assign ld_ready     = (state_q == S_LOAD) && !rst;
   assign load_accept  = ld_ready && ld_valid;
   assign pm_load      = load_accept;
   assign pm_load_addr = wr_ptr_q;
   assign pm_load_ins  = ld_data;
   assign pm_en        = (state_q == S_RUN);
   assign pm_addr      = pc_q;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ir_d         = ir_q;
      ir_pc_d      = ir_pc_q;
      ir_valid_d   = 1'b0;
      wr_ptr_d     = wr_ptr_q;
      load_count_d = load_count_q;
      load_done_d  = 1'b0;
      load_ovf_d   = load_ovf_q;
`ifdef PROGMEM_SEQ_CHECKSUM_EN
      sum_d        = sum_q;
`endif

      case (state_q)
         S_LOAD: begin
            if (load_accept) begin
               wr_ptr_d     = wr_ptr_q + 1'b1;
               load_count_d = {1'b0, wr_ptr_q} + 1'b1;
`ifdef PROGMEM_SEQ_CHECKSUM_EN
               sum_d        = sum_q + ld_data;
`endif
               if (ld_last) begin
                  state_d     = S_IDLE;
                  load_done_d = 1'b1;
               end else if (wr_ptr_q == {ADDR_W{1'b1}}) begin
                  // Memory full without an explicit last word.
                  state_d     = S_IDLE;
                  load_done_d = 1'b1;
                  load_ovf_d  = 1'b1;
               end
            end
         end

         S_RUN: begin
            if (jump) begin
               // Word currently addressed by the old pc is dropped.
               pc_d = jump_addr;
            end else if (!stall) begin
               ir_d       = pm_ins;
               ir_pc_d    = pc_q;
               ir_valid_d = 1'b1;
               if (fetch_is_halt) begin
                  state_d = S_HALTED;
               end else begin
                  pc_d = pc_q + 1'b1;
               end
            end
         end

         default: begin
            // IDLE and HALTED accept the same commands.
            if (start_load) begin
               state_d      = S_LOAD;
               wr_ptr_d     = '0;
               load_ovf_d   = 1'b0;
               load_count_d = '0;
`ifdef PROGMEM_SEQ_CHECKSUM_EN
               sum_d        = '0;
`endif
            end else if (run) begin
               state_d = S_RUN;
               pc_d    = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         pc_q         <= '0;
         ir_q         <= '0;
         ir_pc_q      <= '0;
         ir_valid_q   <= 1'b0;
         wr_ptr_q     <= '0;
         load_count_q <= '0;
         load_done_q  <= 1'b0;
         load_ovf_q   <= 1'b0;
`ifdef PROGMEM_SEQ_CHECKSUM_EN
         sum_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ir_q         <= ir_d;
         ir_pc_q      <= ir_pc_d;
         ir_valid_q   <= ir_valid_d;
         wr_ptr_q     <= wr_ptr_d;
         load_count_q <= load_count_d;
         load_done_q  <= load_done_d;
         load_ovf_q   <= load_ovf_d;
`ifdef PROGMEM_SEQ_CHECKSUM_EN
         sum_q        <= sum_d;
`endif
      end
   end

   assign state      = state_q;
   assign pc         = pc_q;
   assign ir         = ir_q;
   assign ir_pc      = ir_pc_q;
   assign ir_valid   = ir_valid_q;
   assign load_done  = load_done_q;
   assign load_count = load_count_q;
   assign load_ovf   = load_ovf_q;
`ifdef PROGMEM_SEQ_CHECKSUM_EN
   assign load_sum   = sum_q;
`endif

endmodule

// File: tb/tb_progmem_sequencer.sv
// -----------------------------------------------------------------------------
// tb_progmem_sequencer
//
// Testbench for progmem_sequencer: a directed table for the basic
// load/run/halt flow, hand-written sequences for overflow, jump, stall and
// reset, and a randomized phase checked against a cycle-level reference model.
// Build with PROGMEM_SEQ_CHECKSUM_EN defined to also check load_sum.
// -----------------------------------------------------------------------------
module tb_progmem_sequencer;

   localparam int AW    = 8;
   localparam int IW    = 12;
   localparam int DEPTH = 256;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, start_load, run, ld_valid, ld_last, stall, jump;
   logic [IW-1:0] ld_data;
   logic [AW-1:0] jump_addr;
   logic          ld_ready, pm_load, pm_en, ir_valid, load_done, load_ovf;
   logic [AW-1:0] pm_load_addr, pm_addr, ir_pc, pc;
   logic [IW-1:0] pm_load_ins, pm_ins, ir;
   logic [1:0]    state;
   logic [AW:0]   load_count;
`ifdef PROGMEM_SEQ_CHECKSUM_EN
   logic [IW-1:0] load_sum;
`endif

   progmem_sequencer #(.ADDR_W(AW), .INS_W(IW), .HALT_OP(4'hF)) dut (
      .clk(clk), .rst(rst), .start_load(start_load), .run(run),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
      .ld_ready(ld_ready), .stall(stall), .jump(jump), .jump_addr(jump_addr),
      .pm_load(pm_load), .pm_load_addr(pm_load_addr), .pm_load_ins(pm_load_ins),
      .pm_en(pm_en), .pm_addr(pm_addr), .pm_ins(pm_ins),
      .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .pc(pc), .state(state),
      .load_done(load_done), .load_count(load_count), .load_ovf(load_ovf)
`ifdef PROGMEM_SEQ_CHECKSUM_EN
      , .load_sum(load_sum)
`endif
   );

   // Program memory driven only through the DUT write port.
   logic          mem_clear;
   logic [IW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= (i == 3) ? 12'hF00 : 12'h000;
      end else if (pm_load) begin
         mem[pm_load_addr] <= pm_load_ins;
      end
   end
   assign pm_ins = mem[pm_addr];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int            m_state;
   logic [AW-1:0] m_pc, m_wr, m_irpc;
   logic [IW-1:0] m_ir;
   logic          m_irv, m_done, m_ovf;
   logic [AW:0]   m_cnt;
   logic [IW-1:0] m_mem [DEPTH];
`ifdef PROGMEM_SEQ_CHECKSUM_EN
   logic [IW-1:0] m_sum;
`endif

   task automatic model_reset();
      m_state = 0; m_pc = '0; m_wr = '0; m_irpc = '0; m_ir = '0;
      m_irv = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_cnt = '0;
`ifdef PROGMEM_SEQ_CHECKSUM_EN
      m_sum = '0;
`endif
   endtask

   task automatic model_edge();
      logic [IW-1:0] w;
      if (rst) begin
         model_reset();
         return;
      end
      m_done = 1'b0;
      m_irv  = 1'b0;
      case (m_state)
         1: if (ld_valid) begin
               m_mem[m_wr] = ld_data;
`ifdef PROGMEM_SEQ_CHECKSUM_EN
               m_sum = m_sum + ld_data;
`endif
               m_cnt = 9'(m_wr) + 9'd1;
               if (ld_last || m_wr == 8'hFF) begin
                  m_state = 0;
                  m_done  = 1'b1;
                  m_ovf   = !ld_last;
               end
               m_wr = m_wr + 8'd1;
            end
         2: begin
               if (jump) m_pc = jump_addr;
               else if (!stall) begin
                  w      = m_mem[m_pc];
                  m_ir   = w;
                  m_irpc = m_pc;
                  m_irv  = 1'b1;
                  if (w[11:8] == 4'hF) m_state = 3;
                  else m_pc = m_pc + 8'd1;
               end
            end
         default: begin
               if (start_load) begin
                  m_state = 1; m_wr = '0; m_ovf = 1'b0; m_cnt = '0;
`ifdef PROGMEM_SEQ_CHECKSUM_EN
                  m_sum = '0;
`endif
               end else if (run) begin
                  m_state = 2; m_pc = '0;
               end
            end
      endcase
   endtask

   task automatic check_comb();
      chk("ld_ready", 32'(ld_ready), 32'(m_state == 1 && !rst));
      chk("pm_load", 32'(pm_load), 32'(m_state == 1 && !rst && ld_valid));
      chk("pm_load_addr", 32'(pm_load_addr), 32'(m_wr));
      chk("pm_load_ins", 32'(pm_load_ins), 32'(ld_data));
      chk("pm_en", 32'(pm_en), 32'(m_state == 2));
      chk("pm_addr", 32'(pm_addr), 32'(m_pc));
   endtask

   task automatic check_regs();
      chk("state", 32'(state), 32'(m_state));
      chk("pc", 32'(pc), 32'(m_pc));
      chk("ir", 32'(ir), 32'(m_ir));
      chk("ir_pc", 32'(ir_pc), 32'(m_irpc));
      chk("ir_valid", 32'(ir_valid), 32'(m_irv));
      chk("load_done", 32'(load_done), 32'(m_done));
      chk("load_count", 32'(load_count), 32'(m_cnt));
      chk("load_ovf", 32'(load_ovf), 32'(m_ovf));
`ifdef PROGMEM_SEQ_CHECKSUM_EN
      chk("load_sum", 32'(load_sum), 32'(m_sum));
`endif
   endtask

   task automatic tick();
      #1;
      check_comb();
      model_edge();
      @(posedge clk);
      #1;
      check_regs();
   endtask

   task automatic clr_in();
      rst = 0; start_load = 0; run = 0; ld_valid = 0; ld_data = '0;
      ld_last = 0; stall = 0; jump = 0; jump_addr = '0;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic          sl, rn, vld, lst;
      logic [IW-1:0] dat;
      logic          e_rdy, e_wr;
      logic [AW-1:0] e_waddr;
      logic [1:0]    e_st;
      logic          e_done, e_irv;
      logic [IW-1:0] e_ir;
      logic [AW-1:0] e_irpc, e_pc;
   } vec_t;

   vec_t          vt [13];
   logic [IW-1:0] ovf_words [DEPTH];

   initial begin
      int cnt, guard;
      //        sl rn vld lst dat      rdy wr waddr  st done irv ir       irpc   pc
      vt[0]  = '{1, 0, 0, 0, 12'h000, 0, 0, 8'h00, 1, 0, 0, 12'h000, 8'h00, 8'h00};
      vt[1]  = '{0, 0, 1, 0, 12'h101, 1, 1, 8'h00, 1, 0, 0, 12'h000, 8'h00, 8'h00};
      vt[2]  = '{0, 0, 0, 0, 12'h000, 1, 0, 8'h01, 1, 0, 0, 12'h000, 8'h00, 8'h00};
      vt[3]  = '{0, 0, 1, 0, 12'h202, 1, 1, 8'h01, 1, 0, 0, 12'h000, 8'h00, 8'h00};
      vt[4]  = '{0, 0, 0, 0, 12'h000, 1, 0, 8'h02, 1, 0, 0, 12'h000, 8'h00, 8'h00};
      vt[5]  = '{0, 0, 1, 1, 12'h3F0, 1, 1, 8'h02, 0, 1, 0, 12'h000, 8'h00, 8'h00};
      vt[6]  = '{0, 0, 0, 0, 12'h000, 0, 0, 8'h03, 0, 0, 0, 12'h000, 8'h00, 8'h00};
      vt[7]  = '{0, 1, 0, 0, 12'h000, 0, 0, 8'h03, 2, 0, 0, 12'h000, 8'h00, 8'h00};
      vt[8]  = '{0, 0, 0, 0, 12'h000, 0, 0, 8'h03, 2, 0, 1, 12'h101, 8'h00, 8'h01};
      vt[9]  = '{0, 0, 0, 0, 12'h000, 0, 0, 8'h03, 2, 0, 1, 12'h202, 8'h01, 8'h02};
      vt[10] = '{0, 0, 0, 0, 12'h000, 0, 0, 8'h03, 2, 0, 1, 12'h3F0, 8'h02, 8'h03};
      // address 3 holds the preset halt word 0xF00
      vt[11] = '{0, 0, 0, 0, 12'h000, 0, 0, 8'h03, 3, 0, 1, 12'hF00, 8'h03, 8'h03};
      vt[12] = '{0, 0, 0, 0, 12'h000, 0, 0, 8'h03, 3, 0, 0, 12'hF00, 8'h03, 8'h03};

      clr_in();
      rst = 1;
      mem_clear = 1;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = (i == 3) ? 12'hF00 : 12'h000;
      repeat (2) @(posedge clk);
      #1;
      mem_clear = 0;
      model_reset();
      check_regs();
      check_comb();
      rst = 0;

      for (int k = 0; k < 13; k++) begin
         start_load = vt[k].sl; run = vt[k].rn; ld_valid = vt[k].vld;
         ld_last = vt[k].lst; ld_data = vt[k].dat;
         #1;
         chk("tbl_ld_ready", 32'(ld_ready), 32'(vt[k].e_rdy));
         chk("tbl_pm_load", 32'(pm_load), 32'(vt[k].e_wr));
         chk("tbl_pm_load_addr", 32'(pm_load_addr), 32'(vt[k].e_waddr));
         tick();
         chk("tbl_state", 32'(state), 32'(vt[k].e_st));
         chk("tbl_load_done", 32'(load_done), 32'(vt[k].e_done));
         chk("tbl_ir_valid", 32'(ir_valid), 32'(vt[k].e_irv));
         chk("tbl_ir", 32'(ir), 32'(vt[k].e_ir));
         chk("tbl_ir_pc", 32'(ir_pc), 32'(vt[k].e_irpc));
         chk("tbl_pc", 32'(pc), 32'(vt[k].e_pc));
         $display("row %0d: state=%0d ir_valid=%0b ir=%h ir_pc=%h pc=%h", k, state, ir_valid, ir, ir_pc, pc);
      end
      clr_in();
      chk("tbl_load_count", 32'(load_count), 32'd3);
      chk("tbl_load_ovf", 32'(load_ovf), 32'd0);
`ifdef PROGMEM_SEQ_CHECKSUM_EN
      chk("tbl_load_sum", 32'(load_sum), 32'h6F3);
`endif

      // ---------------- overflow: 256 words, no last ----------------
      start_load = 1;
      tick();
      start_load = 0;
      cnt = 0;
      guard = 0;
      while (cnt < DEPTH && guard < 4000) begin
         ld_valid = ($urandom_range(0, 3) != 0);
         ld_data  = {4'($urandom_range(0, 14)), 8'($urandom)};
         if (ld_valid) ovf_words[cnt] = ld_data;
         tick();
         if (ld_valid) cnt++;
         guard++;
      end
      chk("ovf_words_sent", 32'(cnt), 32'(DEPTH));
      ld_valid = 0;
      chk("ovf_state", 32'(state), 32'd0);
      chk("ovf_load_done", 32'(load_done), 32'd1);
      chk("ovf_load_ovf", 32'(load_ovf), 32'd1);
      chk("ovf_load_count", 32'(load_count), 32'd256);
      $display("overflow load: count=%0d ovf=%0b", load_count, load_ovf);
      tick();
      chk("ovf_done_pulse", 32'(load_done), 32'd0);

      // ---------------- jump / stall ----------------
      run = 1;
      tick();
      run = 0;
      repeat (5) tick();
      chk("pre_jump_pc", 32'(pc), 32'd5);
      jump = 1; jump_addr = 8'h80;
      tick();
      jump = 0;
      chk("jump_irv", 32'(ir_valid), 32'd0);
      chk("jump_pc", 32'(pc), 32'h80);
      chk("jump_ir_hold", 32'(ir), 32'(ovf_words[4]));
      tick();
      chk("jump_first_irpc", 32'(ir_pc), 32'h80);
      chk("jump_first_ir", 32'(ir), 32'(ovf_words[8'h80]));
      chk("jump_first_irv", 32'(ir_valid), 32'd1);
      $display("jump: ir_pc=%h ir=%h", ir_pc, ir);
      jump = 1; jump_addr = 8'h04;
      tick();
      jump = 0;
      chk("to4_pc", 32'(pc), 32'd4);
      stall = 1;
      for (int s = 0; s < 3; s++) begin
         tick();
         chk("stall_irv", 32'(ir_valid), 32'd0);
         chk("stall_pc", 32'(pc), 32'd4);
         chk("stall_ir", 32'(ir), 32'(ovf_words[8'h80]));
         $display("stall %0d: pc=%h ir=%h", s, pc, ir);
      end
      stall = 0;
      tick();
      chk("resume_irpc", 32'(ir_pc), 32'd4);
      chk("resume_ir", 32'(ir), 32'(ovf_words[4]));
      chk("resume_pc", 32'(pc), 32'd5);
      stall = 1; jump = 1; jump_addr = 8'h10;
      tick();
      stall = 0; jump = 0;
      chk("stalljump_pc", 32'(pc), 32'h10);
      chk("stalljump_irv", 32'(ir_valid), 32'd0);

      // ---------------- resets ----------------
      rst = 1;
      tick();
      rst = 0;
      chk("rstrun_state", 32'(state), 32'd0);
      chk("rstrun_pc", 32'(pc), 32'd0);
      chk("rstrun_ir", 32'(ir), 32'd0);
      chk("rstrun_count", 32'(load_count), 32'd0);
      start_load = 1;
      tick();
      start_load = 0;
      ld_valid = 1; ld_data = 12'hABC;
      tick();
      ld_data = 12'h123;
      tick();
      ld_valid = 0;
      rst = 1; ld_valid = 1; ld_data = 12'h555;
      tick();
      rst = 0; ld_valid = 0;
      chk("rstload_state", 32'(state), 32'd0);
      chk("rstload_count", 32'(load_count), 32'd0);
      chk("rstload_ovf", 32'(load_ovf), 32'd0);
      run = 1;
      tick();
      run = 0;
      tick();
      chk("rstload_fetch_ir", 32'(ir), 32'hABC);
      chk("rstload_fetch_irpc", 32'(ir_pc), 32'd0);
      chk("rstload_fetch_irv", 32'(ir_valid), 32'd1);
      tick();
      chk("rstload_second", 32'(ir), 32'h123);
      $display("after reset: ir=%h ir_pc=%h", ir, ir_pc);

      // ---------------- randomized ----------------
      for (int c = 0; c < 3000; c++) begin
         rst        = ($urandom_range(0, 149) == 0);
         start_load = ($urandom_range(0, 29) == 0);
         run        = ($urandom_range(0, 19) == 0);
         ld_valid   = ($urandom_range(0, 1) == 0);
         ld_data    = 12'($urandom);
         ld_last    = ($urandom_range(0, 19) == 0);
         stall      = ($urandom_range(0, 3) == 0);
         jump       = ($urandom_range(0, 9) == 0);
         jump_addr  = 8'($urandom);
         tick();
         if (ir_valid) $display("fetch: ir_pc=%h ir=%h state=%0d", ir_pc, ir, state);
      end
      clr_in();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
